// File: rtl/square_sweep_channel.sv
// Duty-cycle square channel: sweep, envelope and length counter. Amp is registered one cycle behind the step/volume state.
// No backpressure: the ticks are one-cycle enables and every output is a free-running level or pulse.
module square_sweep_channel #(
    parameter int FREQ_W    = 11,
    parameter int LEN_W     = 6,
    parameter int VOL_W     = 4,
    parameter int ENV_PER_W = 3,
    parameter int SWEEP_EN  = 1,
    parameter int SWP_PER_W = 3,
    parameter int SHIFT_W   = 3
) (
    input  logic                 ajer_2mhz,
    input  logic                 apu_reset,
    input  logic                 tick_freq,
    input  logic                 tick_len,
    input  logic                 tick_swp,
    input  logic                 tick_env,
    input  logic                 trigger,
    input  logic                 len_wr,
    input  logic [LEN_W-1:0]     len_init,
    input  logic                 len_en,
    input  logic [1:0]           duty,
    input  logic [FREQ_W-1:0]    freq,
    input  logic [VOL_W-1:0]     vol_init,
    input  logic                 env_up,
    input  logic [ENV_PER_W-1:0] env_per,
    input  logic [SWP_PER_W-1:0] swp_per,
    input  logic                 swp_neg,
    input  logic [SHIFT_W-1:0]   swp_shift,
    output logic [FREQ_W-1:0]    freq_out,
    output logic                 freq_upd,
    output logic                 active,
    output logic                 dac_en,
    output logic [VOL_W-1:0]     amp
);

    localparam logic [SWP_PER_W:0] SWP_FULL = {1'b1, {SWP_PER_W{1'b0}}};
    localparam logic [FREQ_W:0]    FREQ_MAX = {1'b0, {FREQ_W{1'b1}}};

    logic [FREQ_W-1:0]    timer_q, timer_d;
    logic [2:0]           step_q, step_d;
    logic [LEN_W-1:0]     len_cnt_q, len_cnt_d;
    logic                 len_halt_q, len_halt_d;
    logic [VOL_W-1:0]     vol_q, vol_d;
    logic [ENV_PER_W-1:0] env_cnt_q, env_cnt_d;
    logic [SWP_PER_W-1:0] swp_cnt_q, swp_cnt_d;
    logic [FREQ_W-1:0]    shadow_q, shadow_d;
    logic                 swp_on_q, swp_on_d;
    logic                 ovf_chk_q, ovf_chk_d;
    logic                 swept_q, swept_d;
    logic                 active_q, active_d;
    logic [VOL_W-1:0]     amp_q, amp_d;
    logic [FREQ_W-1:0]    freq_out_q, freq_out_d;
    logic                 freq_upd_q, freq_upd_d;

    logic [ENV_PER_W:0]   env_inc;
    logic [SWP_PER_W:0]   swp_inc;
    logic [SWP_PER_W:0]   swp_per_eff;
    logic [FREQ_W:0]      swp_base;
    logic [FREQ_W:0]      swp_n;
    logic                 swp_ovf;
    logic                 swp_ovf2;

    function automatic logic duty_bit(input logic [1:0] d, input logic [2:0] s);
        logic b;
        case (d)
            2'd0:    b = (s == 3'd7);
            2'd1:    b = (s == 3'd0) || (s == 3'd7);
            2'd2:    b = (s == 3'd0) || (s >= 3'd5);
            default: b = (s != 3'd0) && (s != 3'd7);
        endcase
        return b;
    endfunction

    assign dac_en = (vol_init != '0) || env_up;

    // Sweep target from the shadow, plus the follow-up check on that target.
    always_comb begin
        swp_base    = {1'b0, shadow_q};
        swp_n       = swp_neg ? (swp_base - (swp_base >> swp_shift))
                              : (swp_base + (swp_base >> swp_shift));
        swp_ovf     = !swp_neg && (swp_n > FREQ_MAX);
        swp_ovf2    = !swp_neg &&
                      (({1'b0, swp_n[FREQ_W-1:0]} + ({1'b0, swp_n[FREQ_W-1:0]} >> swp_shift)) > FREQ_MAX);
        env_inc     = {1'b0, env_cnt_q} + (ENV_PER_W+1)'(1);
        swp_inc     = {1'b0, swp_cnt_q} + (SWP_PER_W+1)'(1);
        swp_per_eff = (swp_per == '0) ? SWP_FULL : {1'b0, swp_per};
    end

    always_comb begin
        timer_d    = timer_q;
        step_d     = step_q;
        len_cnt_d  = len_cnt_q;
        len_halt_d = len_halt_q;
        vol_d      = vol_q;
        env_cnt_d  = env_cnt_q;
        swp_cnt_d  = swp_cnt_q;
        shadow_d   = shadow_q;
        swp_on_d   = swp_on_q;
        ovf_chk_d  = 1'b0;
        swept_d    = swept_q;
        active_d   = active_q;
        freq_out_d = freq_out_q;
        freq_upd_d = 1'b0;

        if (trigger) begin
            active_d   = 1'b1;
            timer_d    = freq;
            vol_d      = vol_init;
            env_cnt_d  = '0;
            swp_cnt_d  = '0;
            shadow_d   = freq;
            freq_out_d = freq;
            swept_d    = 1'b0;
            swp_on_d   = (SWEEP_EN != 0) && ((swp_per != '0) || (swp_shift != '0));
            ovf_chk_d  = (SWEEP_EN != 0) && (swp_shift != '0);
        end else begin
            // Until the sweep writes a value, register writes flow through to the next reload.
            if (active_q && !swept_q) begin
                shadow_d   = freq;
                freq_out_d = freq;
            end

            if (tick_freq) begin
                if (&timer_q) begin
                    timer_d = freq_out_q;
                    step_d  = step_q + 3'd1;
                end else begin
                    timer_d = timer_q + FREQ_W'(1);
                end
            end

            if (len_wr) begin
                len_cnt_d  = len_init;
                len_halt_d = 1'b0;
            end else if (tick_len && len_en && !len_halt_q) begin
                if (&len_cnt_q) begin
                    len_cnt_d  = '0;
                    len_halt_d = 1'b1;
                    active_d   = 1'b0;
                end else begin
                    len_cnt_d = len_cnt_q + LEN_W'(1);
                end
            end

            if (tick_env && (env_per != '0)) begin
                if (env_inc >= {1'b0, env_per}) begin
                    env_cnt_d = '0;
                    if (env_up && (vol_q != '1)) begin
                        vol_d = vol_q + VOL_W'(1);
                    end else if (!env_up && (vol_q != '0)) begin
                        vol_d = vol_q - VOL_W'(1);
                    end
                end else begin
                    env_cnt_d = env_inc[ENV_PER_W-1:0];
                end
            end

            if (SWEEP_EN != 0) begin
                if (ovf_chk_q && swp_ovf) begin
                    active_d = 1'b0;
                end
                if (tick_swp && swp_on_q) begin
                    if (swp_inc >= swp_per_eff) begin
                        swp_cnt_d = '0;
                        if (swp_ovf) begin
                            active_d = 1'b0;
                        end else if ((swp_shift != '0) && (swp_per != '0)) begin
                            shadow_d   = swp_n[FREQ_W-1:0];
                            freq_out_d = swp_n[FREQ_W-1:0];
                            freq_upd_d = 1'b1;
                            swept_d    = 1'b1;
                            if (swp_ovf2) begin
                                active_d = 1'b0;
                            end
                        end
                    end else begin
                        swp_cnt_d = swp_inc[SWP_PER_W-1:0];
                    end
                end
            end
        end

        if (!dac_en) begin
            active_d = 1'b0;
        end

        // Blank for the trigger cycle so a restart never emits one sample of the old volume.
        if (trigger) begin
            amp_d = '0;
        end else if (active_q && duty_bit(duty, step_q)) begin
            amp_d = vol_q;
        end else begin
            amp_d = '0;
        end
    end

    always_ff @(posedge ajer_2mhz) begin
        if (apu_reset) begin
            timer_q    <= '0;
            step_q     <= '0;
            len_cnt_q  <= '0;
            len_halt_q <= 1'b0;
            vol_q      <= '0;
            env_cnt_q  <= '0;
            swp_cnt_q  <= '0;
            shadow_q   <= '0;
            swp_on_q   <= 1'b0;
            ovf_chk_q  <= 1'b0;
            swept_q    <= 1'b0;
            active_q   <= 1'b0;
            amp_q      <= '0;
            freq_out_q <= '0;
            freq_upd_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            step_q     <= step_d;
            len_cnt_q  <= len_cnt_d;
            len_halt_q <= len_halt_d;
            vol_q      <= vol_d;
            env_cnt_q  <= env_cnt_d;
            swp_cnt_q  <= swp_cnt_d;
            shadow_q   <= shadow_d;
            swp_on_q   <= swp_on_d;
            ovf_chk_q  <= ovf_chk_d;
            swept_q    <= swept_d;
            active_q   <= active_d;
            amp_q      <= amp_d;
            freq_out_q <= freq_out_d;
            freq_upd_q <= freq_upd_d;
        end
    end

    assign freq_out = freq_out_q;
    assign freq_upd = freq_upd_q;
    assign active   = active_q;
    assign amp      = amp_q;

endmodule
